// File: rtl/cpu_ram_pkg.sv
// Shared sizes, FSM encoding and parity helper for the CPU RAM block.
// CPU_RAM_PARITY_EN widens each stored word by one even-parity bit.
package cpu_ram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 256;

`ifdef CPU_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    LD_ACC  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit that makes the stored word (data + parity) have an even number of ones.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_array_256x8.sv
// Single-port storage: synchronous write, registered read (read-before-write).
// Word width follows MEM_W so the parity build carries the extra bit.
module ram_array_256x8
  import cpu_ram_pkg::*;
#(
  parameter int unsigned W = MEM_W
) (
  input  logic              clk_qzt,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_qzt) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_ram.sv
// CPU-facing RAM with a host program-load port; CPU steps win arbitration.
// Optional CPU_RAM_PARITY_EN adds per-word even parity and a sticky error flag.
module cpu_ram
  import cpu_ram_pkg::*;
(
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              en,
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              write_en,
  output logic [DATA_W-1:0] data_rd,
  output logic              rd_valid,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              parity_err
);

  state_t            state;
  logic              clk_in_old;
  logic              pending;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;

  logic              step_c;
  logic              serve_c;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [MEM_W-1:0]  ram_wdata;
  logic [MEM_W-1:0]  ram_rdata;

  assign step_c  = clk_in & ~clk_in_old & en;
  assign serve_c = step_c | pending;

  assign ld_ready = ~reset & (state == IDLE) & ~serve_c;
  assign busy     = (state != IDLE);

  // In IDLE the CPU address goes straight to the RAM so read data lands in CPU_ACC.
  assign ram_addr = (state == IDLE) ? data_addr : addr_q;
  assign ram_we   = ~reset & (((state == CPU_ACC) & wr_q) | (state == LD_ACC));

`ifdef CPU_RAM_PARITY_EN
  assign ram_wdata = {even_par(wdata_q), wdata_q};
`else
  assign ram_wdata = wdata_q;
`endif

  ram_array_256x8 #(.W(MEM_W)) u_ram (
    .clk_qzt (clk_qzt),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state      <= IDLE;
      clk_in_old <= 1'b0;
      pending    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      data_rd    <= '0;
      rd_valid   <= 1'b0;
`ifdef CPU_RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      clk_in_old <= clk_in;
      rd_valid   <= 1'b0;
      // A step seen mid-access is remembered once; further steps are dropped.
      if ((state != IDLE) && step_c) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (serve_c) begin
            state   <= CPU_ACC;
            addr_q  <= data_addr;
            wdata_q <= data_wr;
            wr_q    <= write_en;
            pending <= 1'b0;
          end else if (ld_valid && ld_ready) begin
            state   <= LD_ACC;
            addr_q  <= ld_addr;
            wdata_q <= ld_data;
          end
        end
        CPU_ACC: begin
          if (!wr_q) begin
            data_rd  <= ram_rdata[DATA_W-1:0];
            rd_valid <= 1'b1;
`ifdef CPU_RAM_PARITY_EN
            if (^ram_rdata) parity_err <= 1'b1;
`endif
          end
          state <= DONE;
        end
        LD_ACC:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CPU_RAM_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ram.sv
// Randomized bench for cpu_ram against a cycle-countdown behavioural model,
// plus directed literal checks; parity injection runs when CPU_RAM_PARITY_EN is set.
module tb_cpu_ram;

  logic       clk_qzt = 1'b0;
  logic       reset, en, clk_in, write_en, ld_valid;
  logic [7:0] data_addr, data_wr, ld_addr, ld_data;
  logic [7:0] data_rd;
  logic       rd_valid, ld_ready, busy, parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_qzt = ~clk_qzt;

  cpu_ram dut (
    .clk_qzt    (clk_qzt),
    .reset      (reset),
    .en         (en),
    .clk_in     (clk_in),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .write_en   (write_en),
    .data_rd    (data_rd),
    .rd_valid   (rd_valid),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .busy       (busy),
    .parity_err (parity_err)
  );

  // Model: an access occupies the two cycles after it is accepted (countdown 2,1).
  logic [7:0] m_mem [256];
  bit         m_flip [256];
  logic [1:0] m_cnt;
  logic       m_is_ld, m_w, m_pend, m_clk_old, m_valid, m_perr;
  logic [7:0] m_a, m_d, m_rd;
  bit         started = 1'b0;
  logic       flip_req = 1'b0;
  logic [7:0] flip_addr = 8'h00;

  always @(posedge clk_qzt) begin : model
    logic stp;
    stp = clk_in & ~m_clk_old & en;
    m_clk_old <= reset ? 1'b0 : clk_in;
    m_valid   <= 1'b0;
    started   <= 1'b1;
    if (reset) begin
      m_cnt  <= 2'd0;
      m_pend <= 1'b0;
      m_rd   <= 8'h00;
      m_perr <= 1'b0;
    end else if (m_cnt == 2'd0) begin
      if (stp || m_pend) begin
        m_cnt <= 2'd2; m_is_ld <= 1'b0; m_pend <= 1'b0;
        m_a <= data_addr; m_d <= data_wr; m_w <= write_en;
      end else if (ld_valid) begin
        m_cnt <= 2'd2; m_is_ld <= 1'b1;
        m_a <= ld_addr; m_d <= ld_data;
      end
    end else if (m_cnt == 2'd2) begin
      if (m_is_ld || m_w) begin
        m_mem[m_a]  <= m_d;
        m_flip[m_a] <= 1'b0;
      end else begin
        m_rd    <= m_mem[m_a];
        m_valid <= 1'b1;
        if (m_flip[m_a]) m_perr <= 1'b1;
      end
      if (stp) m_pend <= 1'b1;
      m_cnt <= 2'd1;
    end else begin
      if (stp) m_pend <= 1'b1;
      m_cnt <= 2'd0;
    end
    if (flip_req) m_flip[flip_addr] <= 1'b1;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_qzt) begin : compare
    logic stp_now;
    if (started) begin
      stp_now = clk_in & ~m_clk_old & en;
      chk("data_rd",    data_rd,           m_rd);
      chk("rd_valid",   8'(rd_valid),      8'(m_valid));
      chk("busy",       8'(busy),          8'(m_cnt != 2'd0));
      chk("ld_ready",   8'(ld_ready),      8'(~reset & (m_cnt == 2'd0) & ~(stp_now | m_pend)));
      chk("parity_err", 8'(parity_err),    8'(m_perr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_qzt);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk_qzt);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    ld_addr = a; ld_data = d; ld_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_qzt);
      #2;
      if (ld_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ld_timeout", 8'(ok), 8'd1);
    cyc(1);
    ld_valid = 1'b0;
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w);
    data_addr = a; data_wr = d; write_en = w; clk_in = 1'b1;
    cyc(1);
    clk_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waits;
    logic hs;
    reset = 1'b1; en = 1'b1; clk_in = 1'b0; write_en = 1'b0; ld_valid = 1'b0;
    data_addr = 8'h00; data_wr = 8'h00; ld_addr = 8'h00; ld_data = 8'h00;
    cyc(3);
    wait_neg();
    chk("rst_data_rd",  data_rd, 8'h00);
    chk("rst_rd_valid", 8'(rd_valid), 8'd0);
    chk("rst_busy",     8'(busy), 8'd0);
    chk("rst_ld_ready", 8'(ld_ready), 8'd0);
    chk("rst_perr",     8'(parity_err), 8'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Load then CPU read: data two cycles after the step-detect cycle.
    do_load(8'h10, 8'hC3);
    cyc(2);
    step(8'h10, 8'h00, 1'b0);
    wait_neg(); chk("rd_lat1_valid", 8'(rd_valid), 8'd0);
    wait_neg(); chk("rd_lat2_data", data_rd, 8'hC3); chk("rd_lat2_valid", 8'(rd_valid), 8'd1);
    wait_neg(); chk("rd_pulse_end", 8'(rd_valid), 8'd0); chk("rd_hold", data_rd, 8'hC3);
    cyc(1);

    // CPU write leaves data_rd alone, read-back returns it.
    step(8'h20, 8'h5A, 1'b1);
    wait_neg(); wait_neg();
    chk("wr_no_valid", 8'(rd_valid), 8'd0);
    chk("wr_keeps_rd", data_rd, 8'hC3);
    cyc(1);
    step(8'h20, 8'h00, 1'b0);
    wait_neg(); wait_neg();
    chk("rd_after_wr", data_rd, 8'h5A);
    cyc(1);

    // Step and load request together: CPU first, load after DONE.
    data_addr = 8'h20; write_en = 1'b0; clk_in = 1'b1;
    ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 8'h96;
    wait_neg(); chk("ldr_conflict", 8'(ld_ready), 8'd0);
    cyc(1);
    clk_in = 1'b0;
    waits = 0;
    for (int k = 0; k < 10; k++) begin
      wait_neg();
      if (ld_ready) break;
      waits++;
    end
    chk("ld_wait_cycles", 8'(waits), 8'd2);
    chk("ldr_after_done", 8'(ld_ready), 8'd1);
    cyc(1);
    ld_valid = 1'b0;
    cyc(2);
    step(8'h30, 8'h00, 1'b0);
    wait_neg(); wait_neg();
    chk("ld_committed", data_rd, 8'h96);
    cyc(1);

    // Reset during a CPU write aborts it; memory keeps the old word.
    do_load(8'h40, 8'h77);
    cyc(2);
    step(8'h40, 8'hFF, 1'b1);
    reset = 1'b1;
    cyc(1);
    wait_neg();
    chk("abort_data_rd",  data_rd, 8'h00);
    chk("abort_rd_valid", 8'(rd_valid), 8'd0);
    chk("abort_busy",     8'(busy), 8'd0);
    chk("abort_ld_ready", 8'(ld_ready), 8'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    step(8'h40, 8'h00, 1'b0);
    wait_neg(); wait_neg();
    chk("abort_no_commit", data_rd, 8'h77);
    cyc(1);

    // Disabled: clk_in edges are ignored.
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk_in = ~clk_in;
      wait_neg();
      chk("en_off_busy", 8'(busy), 8'd0);
      cyc(1);
    end
    clk_in = 1'b0;
    cyc(1);
    en = 1'b1;

    // Randomized traffic over a preloaded window.
    for (int i = 0; i < 16; i++) begin
      do_load(8'h80 | 8'(i), 8'($urandom));
      cyc(2);
    end
    hs = 1'b0;
    for (int i = 0; i < 800; i++) begin
      wait_neg();
      hs = ld_valid & ld_ready;
      cyc(1);
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) clk_in = ~clk_in;
      if (!clk_in) begin
        data_addr = 8'h80 | 8'($urandom_range(0, 15));
        data_wr   = 8'($urandom);
        write_en  = 1'($urandom_range(0, 1));
      end
      if (!ld_valid || hs) begin
        ld_valid = ($urandom_range(0, 2) == 0);
        ld_addr  = 8'h80 | 8'($urandom_range(0, 15));
        ld_data  = 8'($urandom);
      end
    end
    reset = 1'b0; ld_valid = 1'b0; clk_in = 1'b0; en = 1'b1;
    cyc(4);

`ifdef CPU_RAM_PARITY_EN
    // Corrupt the stored parity bit, then read: sticky error, data unaffected.
    do_load(8'h50, 8'h3C);
    cyc(3);
    dut.u_ram.mem[8'h50][8] = ~dut.u_ram.mem[8'h50][8];
    flip_addr = 8'h50; flip_req = 1'b1;
    cyc(1);
    flip_req = 1'b0;
    step(8'h50, 8'h00, 1'b0);
    wait_neg(); wait_neg();
    chk("par_err_set",  8'(parity_err), 8'd1);
    chk("par_data_ok",  data_rd, 8'h3C);
    cyc(5);
    chk("par_err_stick", 8'(parity_err), 8'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    wait_neg();
    chk("par_err_clear", 8'(parity_err), 8'd0);
    cyc(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_ram.md
CPU_RAM -- requirements
Module: cpu_ram

Interface
REQ-001 SHALL provide: clk_qzt  input  1  free-running system clock; all logic on its rising edge.
REQ-002 SHALL provide: reset  input  1  reset, synchronous, active-high; clock clk_qzt.
REQ-003 SHALL provide: en  input  1  global enable; when low, CPU steps are ignored.
REQ-004 SHALL provide: clk_in  input  1  CPU step clock, sampled on clk_qzt; a step is its 0->1 transition.
REQ-005 SHALL provide: data_addr  input  8  CPU address.
REQ-006 SHALL provide: data_wr  input  8  CPU write data (CPU data_out).
REQ-007 SHALL provide: write_en  input  1  1 = write, 0 = read.
REQ-008 SHALL provide: data_rd  output  8  registered read data (CPU data_in).
REQ-009 SHALL provide: rd_valid  output  1  one-clk_qzt pulse when data_rd updates.
REQ-010 SHALL provide: ld_valid / ld_ready  input / output  1 / 1  host program-load handshake.
REQ-011 SHALL provide: ld_addr, ld_data  input  8, 8  host load address and data.
REQ-012 SHALL provide: busy  output  1  high while FSM is not IDLE.
REQ-013 SHALL provide: parity_err  output  1  sticky parity error flag.

Function
REQ-014 Memory SHALL be 256 x 8, addressed directly by 8-bit address; no wrap logic needed.
REQ-015 Step detect SHALL register clk_in into clk_in_old each clk_qzt; step = clk_in & !clk_in_old & en.
REQ-016 FSM SHALL have states IDLE, CPU_ACC, LD_ACC, DONE.
REQ-017 IDLE + step -> CPU_ACC, latching data_addr, data_wr, write_en in that cycle.
REQ-018 IDLE + no step + ld_valid & ld_ready -> LD_ACC, latching ld_addr, ld_data.
REQ-019 Step and ld_valid in same cycle: CPU SHALL win; ld_ready held low that cycle; load stays pending.
REQ-020 CPU_ACC write: mem[addr] <= data; data_rd unchanged; rd_valid stays 0.
REQ-021 CPU_ACC read: data_rd <= mem[addr]; rd_valid = 1 in the following cycle (DONE).
REQ-022 Read latency: data_rd valid 2 clk_qzt cycles after step-detect cycle, well before next CPU step.
REQ-023 LD_ACC: mem[ld_addr] <= ld_data; never touches data_rd.
REQ-024 CPU_ACC/LD_ACC -> DONE -> IDLE unconditionally; every access lasts exactly 2 cycles.
REQ-025 ld_ready SHALL be 1 only in IDLE with no step detected that cycle.
REQ-026 A step arriving while busy SHALL be held in a 1-deep pending flag and served on return to IDLE; a second step while pending is dropped.
REQ-027 data_rd SHALL hold its value between reads.

Reset
REQ-028 While reset: FSM=IDLE, data_rd=0x00, rd_valid=0, ld_ready=0, busy=0, parity_err=0, clk_in_old=0, pending=0.
REQ-029 Reset mid-access SHALL abort it; a write in CPU_ACC/LD_ACC in the reset cycle SHALL NOT commit.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro CPU_RAM_PARITY_EN defined: each word stores an extra even-parity bit written on every write; read mismatch sets parity_err until reset; data_rd still returns stored data.
REQ-032 Macro undefined: memory is 8 bits wide; parity_err tied 0.

Structure
REQ-033 Package cpu_ram_pkg SHALL hold ADDR_W=8, DATA_W=8, DEPTH=256 and the FSM state encoding.
REQ-034 Storage SHALL be sub-module ram_array_256x8 (single-port, synchronous write, registered read); cpu_ram holds the FSM, arbitration and parity logic.

Verification
REQ-035 Load 0xC3 at 0x10 via ld port, CPU step read addr 0x10 -> data_rd=0xC3, rd_valid pulse 2 cycles after step.
REQ-036 CPU step write 0x5A at 0x20, then read 0x20 -> data_rd=0x5A; write step leaves data_rd unchanged.
REQ-037 Step and ld_valid same cycle (ld_addr 0x30) -> CPU served first, ld_ready rises after DONE, load then commits.
REQ-038 Assert reset during CPU_ACC write 0xFF at 0x40 -> mem[0x40] unchanged, outputs at reset values.
REQ-039 en=0 with clk_in toggling -> no access, busy stays 0.
REQ-040 With CPU_RAM_PARITY_EN: force parity bit flip at 0x50, read 0x50 -> parity_err=1 and stays 1 until reset.
